// File: rtl/vec_pipe_pkg.sv
// rtl/vec_pipe_pkg.sv - shared defaults, payload types and occupancy encoding for the vector ID/EX stage
package vec_pipe_pkg;

   localparam int LANES  = 8;
   localparam int DATA_W = 20;
   localparam int RA_W   = 4;
   localparam int CTRL_W = 9;

   typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic [1:0] alu_src;
      logic [2:0] alu_ctrl;
      logic       spare;
   } ctrl_t;

   typedef struct packed {
      vec_t            rd1;
      vec_t            rd2;
      vec_t            ext;
      logic [RA_W-1:0] ra1;
      logic [RA_W-1:0] ra2;
      logic [RA_W-1:0] wa3;
      ctrl_t           ctrl;
   } stage_payload_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/vec_pipe_slot.sv
// rtl/vec_pipe_slot.sv - one payload register; clearing ctrl outranks a load and leaves data untouched
module vec_pipe_slot
#(
   parameter int DATA_BITS = 1,
   parameter int CTRL_W    = 9
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 clr_ctrl,
   input  logic [DATA_BITS-1:0] d_data,
   input  logic [CTRL_W-1:0]    d_ctrl,
   output logic [DATA_BITS-1:0] q_data,
   output logic [CTRL_W-1:0]    q_ctrl
);
   import vec_pipe_pkg::*;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_data <= '0;
         q_ctrl <= '0;
      end else if (clr_ctrl) begin
         q_ctrl <= '0;
      end else if (load) begin
         q_data <= d_data;
         q_ctrl <= d_ctrl;
      end
   end

endmodule

// File: rtl/vec_pipe_stage.sv
// rtl/vec_pipe_stage.sv - ID/EX vector pipeline stage with 2-entry skid buffer and flush
// Optional perf counters when VEC_PIPE_STAGE_PERF_EN is defined.
module vec_pipe_stage
#(
   parameter int LANES  = 8,
   parameter int DATA_W = 20,
   parameter int RA_W   = 4,
   parameter int CTRL_W = 9
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_rd1,
   input  logic [LANES*DATA_W-1:0] in_rd2,
   input  logic [LANES*DATA_W-1:0] in_ext,
   input  logic [RA_W-1:0]         in_ra1,
   input  logic [RA_W-1:0]         in_ra2,
   input  logic [RA_W-1:0]         in_wa3,
   input  logic [CTRL_W-1:0]       in_ctrl,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_rd1,
   output logic [LANES*DATA_W-1:0] out_rd2,
   output logic [LANES*DATA_W-1:0] out_ext,
   output logic [RA_W-1:0]         out_ra1,
   output logic [RA_W-1:0]         out_ra2,
   output logic [RA_W-1:0]         out_wa3,
   output logic [CTRL_W-1:0]       out_ctrl
`ifdef VEC_PIPE_STAGE_PERF_EN
   ,
   output logic [15:0]             perf_stall_cnt,
   output logic [15:0]             perf_bubble_cnt
`endif
);
   import vec_pipe_pkg::*;

   localparam int VW = LANES * DATA_W;
   localparam int DW = 3 * VW + 3 * RA_W;

   occ_e              state, state_nxt;
   logic              in_ready_q;
   logic              accept, issue;
   logic              load_main, load_skid, main_from_skid;
   logic [DW-1:0]     in_data, main_data, skid_data, main_d;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_dctrl;

   assign in_data  = {in_rd1, in_rd2, in_ext, in_ra1, in_ra2, in_wa3};
   assign in_ready = in_ready_q;
   assign out_valid = (state != EMPTY);
   assign accept   = in_valid & in_ready_q;
   assign issue    = out_valid & out_ready;

   // in_ready is precomputed from the next state so it leaves a flop directly
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_nxt;
         in_ready_q <= (state_nxt != FULL);
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
               if (accept && !issue)      state_nxt = FULL;
               else if (issue && !accept) state_nxt = EMPTY;
            end
            FULL:    if (issue) state_nxt = ONE;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // FULL never accepts, so main reloads either from skid or from the input
   always_comb begin
      main_from_skid = (state == FULL) && out_ready;
      load_main      = main_from_skid ||
                       (accept && ((state == EMPTY) || ((state == ONE) && out_ready)));
      load_skid      = accept && (state == ONE) && !out_ready;
   end

   assign main_d     = main_from_skid ? skid_data : in_data;
   assign main_dctrl = main_from_skid ? skid_ctrl : in_ctrl;

   vec_pipe_slot #(.DATA_BITS(DW), .CTRL_W(CTRL_W)) u_main (
      .clk      (clk),
      .reset    (reset),
      .load     (load_main & ~flush),
      .clr_ctrl (flush),
      .d_data   (main_d),
      .d_ctrl   (main_dctrl),
      .q_data   (main_data),
      .q_ctrl   (main_ctrl)
   );

   vec_pipe_slot #(.DATA_BITS(DW), .CTRL_W(CTRL_W)) u_skid (
      .clk      (clk),
      .reset    (reset),
      .load     (load_skid & ~flush),
      .clr_ctrl (flush),
      .d_data   (in_data),
      .d_ctrl   (in_ctrl),
      .q_data   (skid_data),
      .q_ctrl   (skid_ctrl)
   );

   assign {out_rd1, out_rd2, out_ext, out_ra1, out_ra2, out_wa3} = main_data;
   // main keeps its ctrl after draining to EMPTY, so mask it here
   assign out_ctrl = out_valid ? main_ctrl : '0;

`ifdef VEC_PIPE_STAGE_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && (perf_stall_cnt != 16'hFFFF))
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
         if (!out_valid && out_ready && (perf_bubble_cnt != 16'hFFFF))
            perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/vec_pipe_stage.md
Name: vec_pipe_stage

Overview:
- Parametrised ID/EX pipeline stage for the vector datapath.
- Carries operand vectors, source register addresses, extended immediate vector and the execute control bundle.
- Generalises the fixed 8x20 register buffer with configurable lanes/width, a valid/ready handshake with a 2-entry skid buffer (full throughput, registered in_ready), and a flush that turns in-flight entries into bubbles.
- Sits between the register-file/decode stage and the vector ALU stage.

Parameters:
- LANES, 8, number of vector lanes.
- DATA_W, 20, bits per lane.
- RA_W, 4, register address width (ra1, ra2, wa3).
- CTRL_W, 9, control bundle width: {RegWrite, MemtoReg, MemWrite, ALUSrc[1:0], ALUControl[2:0], spare}.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered.
- in_rd1  in  LANES*DATA_W  operand vector 1.
- in_rd2  in  LANES*DATA_W  operand vector 2.
- in_ext  in  LANES*DATA_W  extended immediate vector.
- in_ra1  in  RA_W  source address 1.
- in_ra2  in  RA_W  source address 2.
- in_wa3  in  RA_W  destination address.
- in_ctrl  in  CTRL_W  control bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_rd1, out_rd2, out_ext  out  LANES*DATA_W  head entry vectors.
- out_ra1, out_ra2, out_wa3  out  RA_W  head entry addresses.
- out_ctrl  out  CTRL_W  head entry control; all-zero whenever out_valid=0.

Behaviour:
- Reset (async assert, sync deassert by the system): both slots invalid; all data, address and control registers 0; in_ready=1; out_valid=0.
- Transfers: accept = in_valid & in_ready; issue = out_valid & out_ready.
- Occupancy FSM:
  - EMPTY: accept goes to ONE.
  - ONE: accept & !issue goes to FULL; issue & !accept goes to EMPTY; accept & issue stays ONE (main slot reloads).
  - FULL: issue moves skid to main and goes to ONE. No accept is possible in FULL.
- Datapath: outputs are driven directly from the main slot. Incoming data goes to main if main is empty or issuing that cycle, else to skid.
- in_ready = !FULL, registered, so there is no combinational in->out path.
- Latency: 1 cycle from accept to out_valid when the stage was EMPTY. Throughput is 1/cycle with out_ready held high.
- Flush (sync, highest priority after reset):
  - Next state is EMPTY.
  - The same-cycle accept is discarded.
  - Control fields of both slots are cleared to 0. Data and address fields are don't-care and hold.
  - An issue in the flush cycle still counts downstream; flush only affects the next state.
- Data stability: out_* must not change while out_valid & !out_ready.
- Reset mid-operation: immediate clear regardless of FSM state.

Optional Feature:
- Macro VEC_PIPE_STAGE_PERF_EN.
- Defined: adds ports perf_stall_cnt (out, 16) and perf_bubble_cnt (out, 16).
  - perf_stall_cnt increments each cycle out_valid & !out_ready, saturating at 16'hFFFF.
  - perf_bubble_cnt increments each cycle !out_valid & out_ready, saturating at 16'hFFFF.
  - Both are cleared by reset only; flush does not clear them.
- Undefined: the ports and counters do not exist, and there is zero added logic.

Decomposition:
- Package vec_pipe_pkg holds:
  - LANES/DATA_W/RA_W defaults;
  - typedef vec_t as logic [LANES-1:0][DATA_W-1:0];
  - packed struct ctrl_t {reg_write, mem_to_reg, mem_write, alu_src[1:0], alu_ctrl[2:0], spare};
  - typedef stage_payload_t bundling the vectors, addresses and ctrl_t;
  - enum occ_e {EMPTY, ONE, FULL}.
- Sub-module vec_pipe_slot: one payload register with load, clear-ctrl and async reset, instantiated twice (main, skid).

Test Plan:
- Reset then stream: reset=1 for 2 cycles, then in_valid=1 with rd1 lane i = i+1, out_ready=1 for 5 entries. Expect out_valid one cycle after the first accept, 5 entries in order, in_ready constantly 1.
- Backpressure: out_ready=0 while sending entries A (ctrl=9'h0A5) and B. Expect state FULL, in_ready=0 on the cycle after B is accepted, out_* = A held stable, C blocked. Then raise out_ready: A, B, C emerge in order with no loss or duplication.
- Flush while FULL: flush=1 with in_valid=1 presenting D. Next cycle out_valid=0, out_ctrl=0, in_ready=1, and D is never seen at the output.
- Simultaneous accept+issue in ONE: out_ready=1, in_valid=1 every cycle with LANES=4, DATA_W=32, lane data 32'hFFFF_FFFF. Expect steady ONE state and exact values propagated.
- Async reset mid-FULL: assert reset between clock edges. Expect out_valid=0, out_ctrl=0 and in_ready=1 immediately, before the next clock edge.
- PERF_EN build: out_ready=0 for 70000 cycles with out_valid=1. Expect perf_stall_cnt=16'hFFFF saturated and perf_bubble_cnt unchanged.
